digital_clock_cfg: RTL and testbench
====================================

// Module: digital_clock_cfg
// PURPOSE
//  Configurable BCD time-of-day clock with six display digits (HH:MM:SS). Successor to the fixed 24-hour clock.
//  Adds: clock prescaler, 12/24-hour display mode with PM flag, validated time load, minute alarm, day-wrap pulse.
//  Drives the display/BCD decode stage. Time is always held internally in 24-hour BCD.
// PARAMETERS
//  TICKS_PER_SEC  1  clk cycles per second; must be >= 1 (1 = one second per enabled clk)
//  TICK_W         derived localparam, $clog2(TICKS_PER_SEC) (min 1), width of the prescaler
// PORTS
//  clk          in   1  system clock, rising edge
//  reset        in   1  asynchronous reset, active-high
//  enable       in   1  1 = prescaler runs and time advances; 0 = prescaler and time frozen
//  mode_12h     in   1  display mode: 0 = 24-hour, 1 = 12-hour (display only, state unaffected)
//  load         in   1  one-cycle strobe: load time from ld_* (24-hour BCD)
//  ld_hr        in   8  BCD hours {tens,units}
//  ld_min       in   8  BCD minutes
//  ld_sec       in   8  BCD seconds
//  alarm_wr     in   1  one-cycle strobe: capture al_hr/al_min (24-hour BCD)
//  al_hr        in   8  BCD alarm hours
//  al_min       in   8  BCD alarm minutes
//  alarm_en     in   1  1 = alarm_hit permitted
//  ms_hr,ls_hr  out  4  displayed hour digits (mode-converted)
//  ms_min,ls_min out 4  minute digits
//  ms_sec,ls_sec out 4  second digits
//  pm           out  1  1 = hours 12..23 (valid in both modes)
//  load_err     out  1  registered 1-cycle pulse: rejected load or alarm_wr
//  day_wrap     out  1  registered 1-cycle pulse: 23:59:59 -> 00:00:00
//  alarm_hit    out  1  registered 1-cycle pulse: tick moved time to alarm HH:MM:00
// BEHAVIOUR
//  - Reset (async): time 00:00:00, prescaler 0, alarm 00:00, all pulses 0. Displays 00:00:00 (24h) or 12:00:00 (12h), pm=0.
//  - Prescaler: counts 0..TICKS_PER_SEC-1 while enable=1; sec_tick when count==TICKS_PER_SEC-1 && enable; count wraps to 0.
//    TICKS_PER_SEC=1: every enabled clk is a tick. enable=0 holds count and time.
//  - Advance on sec_tick, registered, visible the cycle after the tick edge: sec 00..59, carry to min 00..59, carry to hr 00..23.
//    Units digit wraps 9->0 with carry into tens. 23:59:59 -> 00:00:00 with day_wrap=1 in the same cycle the new time appears.
//  - Load: valid iff every digit <= 9 and hr <= 23, min <= 59, sec <= 59. Valid: time <= ld_*, prescaler <= 0.
//    Invalid: time unchanged, load_err=1 next cycle. Load overrides a coincident tick (tick lost).
//    Load works with enable=0. No day_wrap or alarm_hit from a load.
//  - alarm_wr: same validation on al_hr/al_min. Invalid keeps the old alarm and raises load_err.
//    load and alarm_wr in the same cycle are independent; load_err is their OR.
//  - alarm_hit=1 for one cycle when a tick (not a load) makes the time equal to alarm HH:MM:00 and alarm_en=1.
//    alarm_en is sampled on the tick cycle. An alarm of 00:00 hits coincident with day_wrap.
//  - Display (combinational from state, zero latency): pm = (hr >= 12).
//    24h: digits = state. 12h: hr 00 -> 12, 01..12 -> same, 13..23 -> hr-12, all in BCD.
//    mode_12h changes take effect in the same cycle.
//  - Reset mid-operation: immediate clear regardless of load, tick or enable.
// STRUCTURE
//  - Package digital_clock_pkg: BCD limit constants (SEC_MAX=8'h59, MIN_MAX=8'h59, HR_MAX=8'h23),
//    typedef bcd2_t (logic [7:0]), function bcd2_valid(value, max), function to_12h(bcd2_t hr).
//  - Sub-module bcd2_counter #(MAX): two-digit BCD counter with inc, load, ld_val, carry_out (= inc && val==MAX).
//    Instantiated three times (sec/min/hr), chained by carry.
//  - Top-level holds the prescaler, load/alarm validation, alarm register, pulse registers and 12h conversion.
// TESTING
//  1. TICKS_PER_SEC=1, run 5 cycles, assert reset mid-count -> all digits 0 on the same edge; pulses 0.
//  2. load 23:59:58, enable=1 -> 23:59:59, then 00:00:00 with day_wrap=1 for exactly one cycle.
//  3. mode_12h=1: load 00:00:00 -> 12:00:00 pm=0; 12:30:00 -> 12:30:00 pm=1; 13:05:00 -> 01:05:00 pm=1.
//  4. load 24:00:00, then 12:6A:00, then alarm_wr 07:60 -> load_err one cycle each; time and alarm unchanged.
//  5. alarm_wr 07:30, alarm_en=1, load 07:29:59, tick -> 07:30:00 with alarm_hit=1 once.
//     Repeat with alarm_en=0 -> no hit. Load 07:30:00 directly -> no hit.
//  6. TICKS_PER_SEC=4: seconds advance every 4 enabled clks; enable low for 3 clks mid-count delays the tick by 3;
//     load on the tick cycle wins and restarts the prescaler.

Source files
------------

// File: rtl/digital_clock_pkg.sv
// Shared types, limits and helpers for the configurable BCD time-of-day clock.
//   bcd2_t     : two BCD digits {tens, units}
//   bcd2_valid : both digits <= 9 and value <= max (BCD ordering matches numeric ordering)
//   to_12h     : 24-hour BCD hour -> 12-hour BCD hour (00 -> 12, 13..23 -> 01..11)
package digital_clock_pkg;

   typedef logic [7:0] bcd2_t;

   localparam bcd2_t SEC_MAX = 8'h59;
   localparam bcd2_t MIN_MAX = 8'h59;
   localparam bcd2_t HR_MAX  = 8'h23;

   function automatic logic bcd2_valid(input bcd2_t value, input bcd2_t max_val);
      return (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) && (value <= max_val);
   endfunction

   // Goes through binary so the subtract-12 never needs BCD borrow handling.
   function automatic bcd2_t to_12h(input bcd2_t hr);
      logic [4:0] bin;
      bin = (5'(hr[7:4]) * 5'd10) + 5'(hr[3:0]);
      if (bin == 5'd0) begin
         bin = 5'd12;
      end else if (bin > 5'd12) begin
         bin = bin - 5'd12;
      end
      if (bin >= 5'd10) begin
         return {4'd1, 4'(bin - 5'd10)};
      end
      return {4'd0, 4'(bin)};
   endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter wrapping MAX -> 00; load has priority over inc.
//   clk, reset : clock, async active-high reset (clears to 00)
//   inc        : advance by one
//   load       : take ld_val
//   val        : current value
//   nxt        : value after this edge (lets the parent compare against the upcoming time)
//   carry_out  : inc && val == MAX
module bcd2_counter
   import digital_clock_pkg::*;
#(
   parameter bcd2_t MAX = 8'h59
) (
   input  logic  clk,
   input  logic  reset,
   input  logic  inc,
   input  logic  load,
   input  bcd2_t ld_val,
   output bcd2_t val,
   output bcd2_t nxt,
   output logic  carry_out
);

   bcd2_t val_q, val_d;

   // Next value: load, else BCD increment with units 9 -> 0 carrying into tens.
   always_comb begin
      val_d = val_q;
      if (load) begin
         val_d = ld_val;
      end else if (inc) begin
         if (val_q == MAX) begin
            val_d = '0;
         end else if (val_q[3:0] == 4'd9) begin
            val_d = {val_q[7:4] + 4'd1, 4'd0};
         end else begin
            val_d = {val_q[7:4], val_q[3:0] + 4'd1};
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         val_q <= '0;
      end else begin
         val_q <= val_d;
      end
   end

   assign val       = val_q;
   assign nxt       = val_d;
   assign carry_out = inc && (val_q == MAX);

endmodule

// File: rtl/digital_clock_cfg.sv
// Configurable BCD HH:MM:SS clock: prescaler, validated time load, minute alarm,
// day-wrap pulse and 12/24-hour display. Time is always held in 24-hour BCD.
//   clk, reset            : clock, async active-high reset
//   enable                : prescaler and time run when 1
//   mode_12h              : display-only 12-hour mode
//   load, ld_hr/min/sec   : strobe + 24-hour BCD time to load
//   alarm_wr, al_hr/min   : strobe + 24-hour BCD alarm to capture
//   alarm_en              : permits alarm_hit
//   ms_/ls_ hr/min/sec    : displayed digits (combinational from state)
//   pm                    : hour >= 12
//   load_err, day_wrap, alarm_hit : registered one-cycle pulses
module digital_clock_cfg
   import digital_clock_pkg::*;
#(
   parameter int unsigned TICKS_PER_SEC = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       mode_12h,
   input  logic       load,
   input  logic [7:0] ld_hr,
   input  logic [7:0] ld_min,
   input  logic [7:0] ld_sec,
   input  logic       alarm_wr,
   input  logic [7:0] al_hr,
   input  logic [7:0] al_min,
   input  logic       alarm_en,
   output logic [3:0] ms_hr,
   output logic [3:0] ls_hr,
   output logic [3:0] ms_min,
   output logic [3:0] ls_min,
   output logic [3:0] ms_sec,
   output logic [3:0] ls_sec,
   output logic       pm,
   output logic       load_err,
   output logic       day_wrap,
   output logic       alarm_hit
);

   localparam int unsigned TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);

   logic [TICK_W-1:0] presc_q, presc_d;
   bcd2_t             al_hr_q, al_hr_d;
   bcd2_t             al_min_q, al_min_d;
   logic              load_err_q, load_err_d;
   logic              day_wrap_q, day_wrap_d;
   logic              alarm_hit_q, alarm_hit_d;

   logic              sec_tick, ld_ok, al_ok, tick_eff;
   bcd2_t             sec_val, min_val, hr_val;
   bcd2_t             sec_nxt, min_nxt, hr_nxt;
   logic              sec_carry, min_carry, hr_carry;
   bcd2_t             hr_disp;

   // Validation of the load and alarm payloads.
   assign ld_ok = load && bcd2_valid(ld_hr, HR_MAX) && bcd2_valid(ld_min, MIN_MAX)
                       && bcd2_valid(ld_sec, SEC_MAX);
   assign al_ok = alarm_wr && bcd2_valid(al_hr, HR_MAX) && bcd2_valid(al_min, MIN_MAX);

   // A valid load swallows a coincident tick; a rejected load leaves timekeeping alone.
   assign sec_tick = enable && (presc_q == TICK_LAST);
   assign tick_eff = sec_tick && !ld_ok;

   bcd2_counter #(.MAX(SEC_MAX)) u_sec (
      .clk(clk), .reset(reset), .inc(tick_eff), .load(ld_ok), .ld_val(ld_sec),
      .val(sec_val), .nxt(sec_nxt), .carry_out(sec_carry)
   );

   bcd2_counter #(.MAX(MIN_MAX)) u_min (
      .clk(clk), .reset(reset), .inc(sec_carry), .load(ld_ok), .ld_val(ld_min),
      .val(min_val), .nxt(min_nxt), .carry_out(min_carry)
   );

   bcd2_counter #(.MAX(HR_MAX)) u_hr (
      .clk(clk), .reset(reset), .inc(min_carry), .load(ld_ok), .ld_val(ld_hr),
      .val(hr_val), .nxt(hr_nxt), .carry_out(hr_carry)
   );

   // Prescaler, alarm register and pulse next-state.
   always_comb begin
      presc_d  = presc_q;
      al_hr_d  = al_hr_q;
      al_min_d = al_min_q;
      if (ld_ok) begin
         presc_d = '0;
      end else if (enable) begin
         presc_d = sec_tick ? '0 : presc_q + TICK_W'(1);
      end
      if (al_ok) begin
         al_hr_d  = al_hr;
         al_min_d = al_min;
      end
      load_err_d  = (load && !ld_ok) || (alarm_wr && !al_ok);
      day_wrap_d  = hr_carry;
      // sec_carry implies the new seconds are 00; compare the new HH:MM to the stored alarm.
      alarm_hit_d = sec_carry && alarm_en && (min_nxt == al_min_q) && (hr_nxt == al_hr_q);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_q     <= '0;
         al_hr_q     <= '0;
         al_min_q    <= '0;
         load_err_q  <= 1'b0;
         day_wrap_q  <= 1'b0;
         alarm_hit_q <= 1'b0;
      end else begin
         presc_q     <= presc_d;
         al_hr_q     <= al_hr_d;
         al_min_q    <= al_min_d;
         load_err_q  <= load_err_d;
         day_wrap_q  <= day_wrap_d;
         alarm_hit_q <= alarm_hit_d;
      end
   end

   // Display path: zero latency so mode_12h changes show in the same cycle.
   assign hr_disp = mode_12h ? to_12h(hr_val) : hr_val;
   assign {ms_hr, ls_hr}   = hr_disp;
   assign {ms_min, ls_min} = min_val;
   assign {ms_sec, ls_sec} = sec_val;
   assign pm        = (hr_val >= 8'h12);
   assign load_err  = load_err_q;
   assign day_wrap  = day_wrap_q;
   assign alarm_hit = alarm_hit_q;

endmodule

// File: tb/tb_digital_clock_cfg.sv
// Scoreboard bench: two DUTs (1 and 4 clks per second) share stimulus. The driver
// changes inputs on the falling edge and pushes each DUT's expected post-edge outputs
// from a seconds-of-day reference model; the monitor pops and compares after each rising edge.
module tb_digital_clock_cfg;

   localparam int unsigned T_A = 1;
   localparam int unsigned T_B = 4;
   localparam int DAY = 86400;

   typedef struct packed {
      logic [23:0] digits;
      logic        pm;
      logic        err;
      logic        wrap;
      logic        hit;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0, mode_12h = 1'b0, load = 1'b0, alarm_wr = 1'b0, alarm_en = 1'b0;
   logic [7:0] ld_hr = '0, ld_min = '0, ld_sec = '0, al_hr = '0, al_min = '0;

   logic [3:0] a_mh, a_lh, a_mm, a_lm, a_ms, a_ls;
   logic       a_pm, a_err, a_wrap, a_hit;
   logic [3:0] b_mh, b_lh, b_mm, b_lm, b_ms, b_ls;
   logic       b_pm, b_err, b_wrap, b_hit;

   exp_t q_a[$];
   exp_t q_b[$];
   int   checks = 0;
   int   failures = 0;

   // Reference model state: time as seconds of day, alarm as minutes of day.
   int tod[2];
   int cnt[2];
   int alarm_m[2];
   int tps[2];

   // Background inputs applied by each cycle task.
   bit en_v = 1'b0, m12_v = 1'b0, aen_v = 1'b0;

   always #5 clk = ~clk;

   digital_clock_cfg #(.TICKS_PER_SEC(T_A)) u_dut_a (
      .clk(clk), .reset(reset), .enable(enable), .mode_12h(mode_12h),
      .load(load), .ld_hr(ld_hr), .ld_min(ld_min), .ld_sec(ld_sec),
      .alarm_wr(alarm_wr), .al_hr(al_hr), .al_min(al_min), .alarm_en(alarm_en),
      .ms_hr(a_mh), .ls_hr(a_lh), .ms_min(a_mm), .ls_min(a_lm), .ms_sec(a_ms), .ls_sec(a_ls),
      .pm(a_pm), .load_err(a_err), .day_wrap(a_wrap), .alarm_hit(a_hit)
   );

   digital_clock_cfg #(.TICKS_PER_SEC(T_B)) u_dut_b (
      .clk(clk), .reset(reset), .enable(enable), .mode_12h(mode_12h),
      .load(load), .ld_hr(ld_hr), .ld_min(ld_min), .ld_sec(ld_sec),
      .alarm_wr(alarm_wr), .al_hr(al_hr), .al_min(al_min), .alarm_en(alarm_en),
      .ms_hr(b_mh), .ls_hr(b_lh), .ms_min(b_mm), .ls_min(b_lm), .ms_sec(b_ms), .ls_sec(b_ls),
      .pm(b_pm), .load_err(b_err), .day_wrap(b_wrap), .alarm_hit(b_hit)
   );

   function automatic int bcd_bin(input logic [7:0] v);
      if (v[7:4] > 4'd9 || v[3:0] > 4'd9) return -1;
      return int'(v[7:4]) * 10 + int'(v[3:0]);
   endfunction

   function automatic logic [7:0] to_bcd(input int v);
      logic [7:0] r;
      r[7:4] = 4'(v / 10);
      r[3:0] = 4'(v % 10);
      return r;
   endfunction

   function automatic exp_t make_exp(input int t, input bit m12, input bit err,
                                     input bit wrap, input bit hit);
      exp_t e;
      int   h, hd;
      h  = t / 3600;
      hd = h;
      if (m12) begin
         hd = h % 12;
         if (hd == 0) hd = 12;
      end
      e.digits = {to_bcd(hd), to_bcd((t / 60) % 60), to_bcd(t % 60)};
      e.pm     = (h >= 12);
      e.err    = err;
      e.wrap   = wrap;
      e.hit    = hit;
      return e;
   endfunction

   function automatic exp_t act_a();
      return {a_mh, a_lh, a_mm, a_lm, a_ms, a_ls, a_pm, a_err, a_wrap, a_hit};
   endfunction

   function automatic exp_t act_b();
      return {b_mh, b_lh, b_mm, b_lm, b_ms, b_ls, b_pm, b_err, b_wrap, b_hit};
   endfunction

   task automatic cmp(input string name, input exp_t act, input exp_t req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s t=%0t actual digits=%h pm/err/wrap/hit=%b%b%b%b required digits=%h pm/err/wrap/hit=%b%b%b%b",
                  name, $time, act.digits, act.pm, act.err, act.wrap, act.hit,
                  req.digits, req.pm, req.err, req.wrap, req.hit);
      end
   endtask

   // Advance the model by the edge that follows the inputs now applied.
   task automatic model_step();
      int lh, lm, ls, ah, am;
      bit ld_ok, al_ok, tick, wrap, hit, err;
      lh = bcd_bin(ld_hr);
      lm = bcd_bin(ld_min);
      ls = bcd_bin(ld_sec);
      ah = bcd_bin(al_hr);
      am = bcd_bin(al_min);
      ld_ok = load && lh >= 0 && lm >= 0 && ls >= 0 && lh <= 23 && lm <= 59 && ls <= 59;
      al_ok = alarm_wr && ah >= 0 && am >= 0 && ah <= 23 && am <= 59;
      for (int i = 0; i < 2; i++) begin
         wrap = 1'b0;
         hit  = 1'b0;
         err  = 1'b0;
         if (reset) begin
            tod[i] = 0;
            cnt[i] = 0;
            alarm_m[i] = 0;
         end else begin
            tick = enable && (cnt[i] == tps[i] - 1);
            err  = (load && !ld_ok) || (alarm_wr && !al_ok);
            if (ld_ok) begin
               tod[i] = lh * 3600 + lm * 60 + ls;
               cnt[i] = 0;
            end else begin
               if (enable) cnt[i] = tick ? 0 : cnt[i] + 1;
               if (tick) begin
                  tod[i] = (tod[i] + 1) % DAY;
                  wrap   = (tod[i] == 0);
                  hit    = alarm_en && (tod[i] == alarm_m[i] * 60);
               end
            end
            if (al_ok) alarm_m[i] = ah * 60 + am;
         end
         if (i == 0) q_a.push_back(make_exp(tod[i], mode_12h, err, wrap, hit));
         else        q_b.push_back(make_exp(tod[i], mode_12h, err, wrap, hit));
      end
   endtask

   task automatic cyc(input bit do_ld = 1'b0, input logic [7:0] h = 8'h00,
                      input logic [7:0] m = 8'h00, input logic [7:0] s = 8'h00,
                      input bit do_al = 1'b0, input logic [7:0] ah = 8'h00,
                      input logic [7:0] am = 8'h00);
      @(negedge clk);
      reset    = 1'b0;
      enable   = en_v;
      mode_12h = m12_v;
      alarm_en = aen_v;
      load     = do_ld;
      ld_hr    = h;
      ld_min   = m;
      ld_sec   = s;
      alarm_wr = do_al;
      al_hr    = ah;
      al_min   = am;
      model_step();
   endtask

   // Reset is asserted away from the clock edge; outputs must clear immediately.
   task automatic do_reset();
      @(negedge clk);
      reset    = 1'b1;
      enable   = en_v;
      mode_12h = m12_v;
      alarm_en = aen_v;
      load     = 1'b0;
      alarm_wr = 1'b0;
      model_step();
      #1;
      cmp("async_reset_a", act_a(), make_exp(0, m12_v, 1'b0, 1'b0, 1'b0));
      cmp("async_reset_b", act_b(), make_exp(0, m12_v, 1'b0, 1'b0, 1'b0));
   endtask

   // Monitor: one output set per DUT after every rising edge.
   always begin
      @(posedge clk);
      #1;
      if (q_a.size() > 0) cmp("dut_a_tps1", act_a(), q_a.pop_front());
      if (q_b.size() > 0) cmp("dut_b_tps4", act_b(), q_b.pop_front());
   end

   initial begin
      int nt, hh, mm, ss;
      tps[0] = int'(T_A);
      tps[1] = int'(T_B);

      do_reset();
      cyc();
      cyc();

      // Running count interrupted by reset.
      en_v = 1'b1;
      repeat (5) cyc();
      do_reset();
      cyc();

      // Day wrap.
      cyc(1'b1, 8'h23, 8'h59, 8'h58);
      repeat (10) cyc();

      // 12-hour display conversions.
      en_v  = 1'b0;
      m12_v = 1'b1;
      cyc(1'b1, 8'h00, 8'h00, 8'h00);
      cyc();
      cyc(1'b1, 8'h12, 8'h30, 8'h00);
      cyc();
      cyc(1'b1, 8'h13, 8'h05, 8'h00);
      cyc();
      m12_v = 1'b0;
      cyc();

      // Rejected loads and alarm writes.
      cyc(1'b1, 8'h24, 8'h00, 8'h00);
      cyc();
      cyc(1'b1, 8'h12, 8'h6A, 8'h00);
      cyc();
      cyc(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 8'h07, 8'h60);
      cyc();

      // Alarm hit, alarm masked, and alarm time reached by load.
      cyc(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 8'h07, 8'h30);
      aen_v = 1'b1;
      cyc(1'b1, 8'h07, 8'h29, 8'h59);
      en_v = 1'b1;
      repeat (6) cyc();
      en_v  = 1'b0;
      aen_v = 1'b0;
      cyc(1'b1, 8'h07, 8'h29, 8'h59);
      en_v = 1'b1;
      repeat (6) cyc();
      en_v  = 1'b0;
      aen_v = 1'b1;
      cyc(1'b1, 8'h07, 8'h30, 8'h00);
      repeat (2) cyc();

      // Prescaler: enable gaps and loads landing on tick cycles.
      en_v = 1'b1;
      cyc(1'b1, 8'h01, 8'h00, 8'h00);
      repeat (5) cyc();
      en_v = 1'b0;
      repeat (3) cyc();
      en_v = 1'b1;
      repeat (6) cyc();
      cyc(1'b1, 8'h02, 8'h00, 8'h00);
      repeat (6) cyc();

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         en_v  = ($urandom_range(0, 9) != 0);
         aen_v = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 49) == 0) m12_v = ~m12_v;
         if ($urandom_range(0, 599) == 0) begin
            do_reset();
         end else if ($urandom_range(0, 24) == 0) begin
            case ($urandom_range(0, 2))
               0: begin
                  hh = $urandom_range(0, 23);
                  mm = $urandom_range(0, 59);
                  ss = $urandom_range(0, 59);
               end
               1: begin
                  hh = 23;
                  mm = 59;
                  ss = $urandom_range(50, 59);
               end
               default: begin
                  hh = $urandom_range(0, 23);
                  mm = $urandom_range(0, 59);
                  ss = 58;
               end
            endcase
            if ($urandom_range(0, 3) == 0)
               cyc(1'b1, 8'($urandom()), 8'($urandom()), 8'($urandom()));
            else
               cyc(1'b1, to_bcd(hh), to_bcd(mm), to_bcd(ss),
                   ($urandom_range(0, 7) == 0), to_bcd(hh), to_bcd((mm + 1) % 60));
         end else if ($urandom_range(0, 29) == 0) begin
            nt = (tod[0] / 60 + 1) % 1440;
            if ($urandom_range(0, 3) == 0)
               cyc(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 8'($urandom()), 8'($urandom()));
            else
               cyc(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, to_bcd(nt / 60), to_bcd(nt % 60));
         end else begin
            cyc();
         end
      end

      en_v = 1'b0;
      repeat (3) cyc();
      @(posedge clk);
      #3;
      checks++;
      if (q_a.size() + q_b.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain actual=%0d pending required=0", q_a.size() + q_b.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
